// File: rtl/gc_response_rx_if.sv
// Reply-side bundle: the raw data line and sender handshake inbound, the decoded ID/poll replies outbound.
// master = query side (drives line, send, length select); slave = the reply receiver.
interface gc_response_rx_if;
    logic        data_in;
    logic        send;
    logic        controller_init;
    logic [23:0] wavebird_id;
    logic        wavebird_id_ready;
    logic [63:0] buttons;
    logic        buttons_valid;
    logic        rx_error;
    logic        busy;

    modport master (
        output data_in, send, controller_init,
        input  wavebird_id, wavebird_id_ready, buttons, buttons_valid, rx_error, busy
    );

    modport slave (
        input  data_in, send, controller_init,
        output wavebird_id, wavebird_id_ready, buttons, buttons_valid, rx_error, busy
    );
endinterface

// File: rtl/gc_response_rx.sv
// gc_response_rx: decodes the GameCube controller reply (24-bit ID / 64-bit poll); GC_RX_GLITCH_FILTER_EN adds a 3-sample majority filter.
// Result pulses 3 cycles after the raw stop-bit rise (5 with the filter); no backpressure, pulses are fire-and-forget.
module gc_response_rx #(
    parameter int CYCLES_PER_US   = 100,
    parameter int SAMPLE_US       = 2,
    parameter int BIT_TIMEOUT_US  = 6,
    parameter int RESP_TIMEOUT_US = 100
) (
    input  logic            clk100mhz,
    input  logic            rst,
    gc_response_rx_if.slave bus
);
    localparam int SAMPLE_CYC  = SAMPLE_US * CYCLES_PER_US;
    localparam int BIT_TO_CYC  = BIT_TIMEOUT_US * CYCLES_PER_US;
    localparam int RESP_TO_CYC = RESP_TIMEOUT_US * CYCLES_PER_US;
    localparam int CNT_W       = $clog2(RESP_TO_CYC) + 1;

    localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_TO_LAST  = CNT_W'(BIT_TO_CYC - 1);
    localparam logic [CNT_W-1:0] RESP_TO_LAST = CNT_W'(RESP_TO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_LOW, S_WAIT_HIGH, S_WAIT_FALL, S_STOP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       bit_cnt_q, bit_cnt_d;
    logic             len64_q, len64_d;
    logic [63:0]      shift_q, shift_d;
    logic [23:0]      id_q, id_d;
    logic [63:0]      btn_q, btn_d;
    logic             err_q, err_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             line_prev_q, line_prev_d;
    logic             send_prev_q, send_prev_d;

    logic             line;
    logic             fall;
    logic             arm;
    logic             timeout;
    logic [6:0]       n_bits;

`ifdef GC_RX_GLITCH_FILTER_EN
    logic             hist1_q, hist1_d;
    logic             hist2_q, hist2_d;
    logic             filt_q, filt_d;

    // Majority of three consecutive samples: a lone one-cycle pulse never wins.
    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        filt_d  = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
            filt_q  <= 1'b1;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end

    assign line = filt_q;
`else
    assign line = sync2_q;
`endif

    always_comb begin
        sync1_d     = bus.data_in;
        sync2_d     = sync1_q;
        line_prev_d = line;
        send_prev_d = bus.send;
    end

    assign fall   = line_prev_q & ~line;
    assign arm    = send_prev_q & ~bus.send;
    assign n_bits = len64_q ? 7'd64 : 7'd24;

    // State register
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the sender taking the line back wins over every other event.
    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        if (state_q != S_IDLE && bus.send) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (fall) begin
                        state_d = S_LOW;
                    end else if (cnt_q == RESP_TO_LAST) begin
                        state_d = S_IDLE;
                        timeout = 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt_q == SAMPLE_LAST) state_d = S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    if (line) begin
                        state_d = S_WAIT_FALL;
                    end else if (cnt_q == BIT_TO_LAST) begin
                        state_d = S_IDLE;
                        timeout = 1'b1;
                    end
                end
                S_WAIT_FALL: begin
                    if (fall) begin
                        state_d = (bit_cnt_q == n_bits) ? S_STOP : S_LOW;
                    end else if (cnt_q == BIT_TO_LAST) begin
                        state_d = S_IDLE;
                        timeout = 1'b1;
                    end
                end
                S_STOP: begin
                    if (line) begin
                        state_d = S_DONE;
                    end else if (cnt_q == BIT_TO_LAST) begin
                        state_d = S_IDLE;
                        timeout = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Datapath: the reply registers load on the STOP->DONE step so data and pulse line up.
    always_comb begin
        cnt_d     = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        len64_d   = len64_q;
        shift_d   = shift_q;
        id_d      = id_q;
        btn_d     = btn_q;
        err_d     = timeout;
        if (state_q == S_IDLE && state_d == S_ARMED) begin
            bit_cnt_d = '0;
            len64_d   = ~bus.controller_init;
            shift_d   = '0;
        end
        if (state_q == S_LOW && state_d == S_WAIT_HIGH) begin
            shift_d[bit_cnt_q[5:0]] = line;
            bit_cnt_d               = bit_cnt_q + 7'd1;
        end
        if (state_q == S_STOP && state_d == S_DONE) begin
            if (len64_q) btn_d = shift_q;
            else         id_d  = shift_q[23:0];
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            len64_q     <= 1'b0;
            shift_q     <= '0;
            id_q        <= '0;
            btn_q       <= '0;
            err_q       <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
            send_prev_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            len64_q     <= len64_d;
            shift_q     <= shift_d;
            id_q        <= id_d;
            btn_q       <= btn_d;
            err_q       <= err_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            line_prev_q <= line_prev_d;
            send_prev_q <= send_prev_d;
        end
    end

    // Outputs
    always_comb begin
        bus.busy              = (state_q != S_IDLE);
        bus.wavebird_id_ready = (state_q == S_DONE) && !len64_q;
        bus.buttons_valid     = (state_q == S_DONE) && len64_q;
        bus.rx_error          = err_q;
        bus.wavebird_id       = id_q;
        bus.buttons           = btn_q;
    end
endmodule

// File: tb/tb_gc_response_rx.sv
// Self-checking bench for gc_response_rx: randomized controller replies against a bit-list reference model.
module tb_gc_response_rx;
    localparam int CYC_US  = 100;
    localparam int RESP_TO = 100 * CYC_US;
    localparam int BIT_TO  = 6 * CYC_US;
`ifdef GC_RX_GLITCH_FILTER_EN
    localparam int  LINE_LAT  = 4;
    localparam bit  FILTER_ON = 1'b1;
`else
    localparam int  LINE_LAT  = 2;
    localparam bit  FILTER_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    gc_response_rx_if bus();

    gc_response_rx dut (.clk100mhz(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int id_pulses = 0, btn_pulses = 0, err_pulses = 0;
    int last_id_cyc = 0, last_btn_cyc = 0, last_err_cyc = 0, busy_rise_cyc = 0;
    logic busy_prev = 1'b0;

    logic [23:0] exp_id;
    logic [63:0] exp_btn;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wavebird_id_ready === 1'b1) begin id_pulses++; last_id_cyc = cyc; end
        if (bus.buttons_valid === 1'b1) begin btn_pulses++; last_btn_cyc = cyc; end
        if (bus.rx_error === 1'b1) begin err_pulses++; last_err_cyc = cyc; end
        if (bus.busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
        busy_prev = bus.busy;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reply bits: 1 = short low / long high, 0 = long low / short high.
    task automatic drive_bit(input logic b, input bit jitter);
        int lo, hi;
        if (b) begin
            lo = jitter ? int'($urandom_range(80, 120)) : 100;
            hi = jitter ? int'($urandom_range(180, 240)) : 300;
        end else begin
            lo = jitter ? int'($urandom_range(260, 300)) : 300;
            hi = jitter ? int'($urandom_range(40, 80)) : 100;
        end
        bus.data_in = 1'b0;
        tick(lo);
        bus.data_in = 1'b1;
        tick(hi);
    endtask

    task automatic send_bits(input logic [63:0] bits, input int n, input bit jitter);
        for (int k = 0; k < n; k++) drive_bit(bits[k], jitter);
    endtask

    task automatic send_stop(output int rise_cyc);
        bus.data_in = 1'b0;
        tick(100);
        bus.data_in = 1'b1;
        rise_cyc = cyc;
    endtask

    task automatic arm(input logic init);
        bus.controller_init = init;
        bus.send = 1'b1;
        tick(4);
        bus.send = 1'b0;
    endtask

    // Wire order is MSB-first per byte; the receiver stores wire bit k at index k.
    function automatic logic [63:0] wire_order(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bytes [3];
        int k;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        wire_order = '0;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 7; j >= 0; j--) begin
                wire_order[k] = bytes[i][j];
                k++;
            end
        end
    endfunction

    task automatic test_reset;
        rst = 1'b1; bus.data_in = 1'b1; bus.send = 1'b0; bus.controller_init = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(2);
        exp_id = '0; exp_btn = '0;
        checks++; if (bus.wavebird_id !== 24'h0) begin failures++; $display("FAIL reset_id got=%h exp=0", bus.wavebird_id); end
        checks++; if (bus.buttons !== 64'h0) begin failures++; $display("FAIL reset_buttons got=%h exp=0", bus.buttons); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.wavebird_id_ready, bus.buttons_valid, bus.rx_error} !== 3'b000) begin
            failures++; $display("FAIL reset_pulses got=%b exp=000", {bus.wavebird_id_ready, bus.buttons_valid, bus.rx_error});
        end
    endtask

    task automatic test_id_reply;
        int i0, b0, e0, rise;
        i0 = id_pulses; b0 = btn_pulses; e0 = err_pulses;
        arm(1'b1);
        tick(3);
        bus.controller_init = 1'b0;   // must not change the latched length
        tick(1000 - 3);
        send_bits(wire_order(8'h09, 8'h00, 8'h00), 24, 1'b0);
        send_stop(rise);
        tick(20);
        checks++; if (bus.wavebird_id !== 24'h000090) begin failures++; $display("FAIL id_value got=%h exp=000090", bus.wavebird_id); end
        checks++; if (id_pulses - i0 != 1) begin failures++; $display("FAIL id_pulse_count got=%0d exp=1", id_pulses - i0); end
        checks++; if (last_id_cyc - rise != LINE_LAT + 1) begin failures++; $display("FAIL id_latency got=%0d exp=%0d", last_id_cyc - rise, LINE_LAT + 1); end
        checks++; if (bus.buttons !== exp_btn || btn_pulses != b0) begin failures++; $display("FAIL id_buttons_untouched got=%h exp=%h", bus.buttons, exp_btn); end
        checks++; if (err_pulses != e0 || bus.busy !== 1'b0) begin failures++; $display("FAIL id_clean_end err=%0d busy=%b exp 0/0", err_pulses - e0, bus.busy); end
        exp_id = 24'h000090;
    endtask

    task automatic test_poll_reply;
        logic [63:0] bits;
        int i0, b0, e0, rise;
        for (int k = 0; k < 64; k++) bits[k] = (k % 2 == 0);
        i0 = id_pulses; b0 = btn_pulses; e0 = err_pulses;
        arm(1'b0);
        tick(1000);
        send_bits(bits, 64, 1'b1);
        send_stop(rise);
        tick(20);
        checks++; if (bus.buttons !== 64'h5555_5555_5555_5555) begin failures++; $display("FAIL poll_value got=%h exp=5555555555555555", bus.buttons); end
        checks++; if (btn_pulses - b0 != 1) begin failures++; $display("FAIL poll_pulse_count got=%0d exp=1", btn_pulses - b0); end
        checks++; if (last_btn_cyc - rise != LINE_LAT + 1) begin failures++; $display("FAIL poll_latency got=%0d exp=%0d", last_btn_cyc - rise, LINE_LAT + 1); end
        checks++; if (err_pulses != e0 || id_pulses != i0 || bus.wavebird_id !== exp_id) begin
            failures++; $display("FAIL poll_side_effects err=%0d idp=%0d id=%h exp 0/0/%h", err_pulses - e0, id_pulses - i0, bus.wavebird_id, exp_id);
        end
        exp_btn = 64'h5555_5555_5555_5555;
    endtask

    task automatic test_no_response;
        int e0, n;
        e0 = err_pulses;
        arm(1'b0);
        n = 0;
        while (err_pulses == e0 && n < RESP_TO + 200) begin tick(1); n++; end
        tick(3);
        checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL noresp_err_count got=%0d exp=1", err_pulses - e0); end
        checks++; if (last_err_cyc - busy_rise_cyc != RESP_TO) begin failures++; $display("FAIL noresp_timing got=%0d exp=%0d", last_err_cyc - busy_rise_cyc, RESP_TO); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL noresp_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.buttons !== exp_btn || bus.wavebird_id !== exp_id) begin
            failures++; $display("FAIL noresp_outputs got=%h/%h exp=%h/%h", bus.buttons, bus.wavebird_id, exp_btn, exp_id);
        end
    endtask

    task automatic test_truncated;
        logic [63:0] bits;
        int b0, e0, rise, n;
        bits = {$urandom, $urandom};
        bits[29] = 1'b0;
        b0 = btn_pulses; e0 = err_pulses;
        arm(1'b0);
        tick(200);
        send_bits(bits, 29, 1'b1);
        bus.data_in = 1'b0;
        tick(300);
        bus.data_in = 1'b1;
        rise = cyc;
        n = 0;
        while (err_pulses == e0 && n < BIT_TO + 200) begin tick(1); n++; end
        tick(3);
        checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL trunc_err_count got=%0d exp=1", err_pulses - e0); end
        checks++; if (last_err_cyc - rise != BIT_TO + LINE_LAT + 1) begin failures++; $display("FAIL trunc_timing got=%0d exp=%0d", last_err_cyc - rise, BIT_TO + LINE_LAT + 1); end
        checks++; if (bus.buttons !== exp_btn || btn_pulses != b0) begin failures++; $display("FAIL trunc_buttons got=%h exp=%h", bus.buttons, exp_btn); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL trunc_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_send_abort;
        int i0, b0, e0;
        i0 = id_pulses; b0 = btn_pulses; e0 = err_pulses;
        arm(1'b0);
        tick(200);
        send_bits({$urandom, $urandom}, 5, 1'b1);
        bus.send = 1'b1;
        tick(5);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        tick(BIT_TO + 100);
        checks++; if (err_pulses != e0 || id_pulses != i0 || btn_pulses != b0) begin
            failures++; $display("FAIL abort_pulses err=%0d id=%0d btn=%0d exp 0/0/0", err_pulses - e0, id_pulses - i0, btn_pulses - b0);
        end
        checks++; if (bus.buttons !== exp_btn) begin failures++; $display("FAIL abort_buttons got=%h exp=%h", bus.buttons, exp_btn); end
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] bits;
        int i0, b0, e0, rise;
        i0 = id_pulses; b0 = btn_pulses; e0 = err_pulses;
        arm(1'b1);
        tick(200);
        send_bits({$urandom, $urandom}, 13, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(BIT_TO + 100);
        exp_id = '0; exp_btn = '0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.buttons !== exp_btn || bus.wavebird_id !== exp_id) begin
            failures++; $display("FAIL rstmid_cleared got=%h/%h exp=0/0", bus.buttons, bus.wavebird_id);
        end
        checks++; if (err_pulses != e0 || id_pulses != i0 || btn_pulses != b0) begin
            failures++; $display("FAIL rstmid_pulses err=%0d id=%0d btn=%0d exp 0/0/0", err_pulses - e0, id_pulses - i0, btn_pulses - b0);
        end
        bits = {$urandom, $urandom};
        arm(1'b1);
        tick(300);
        send_bits(bits, 24, 1'b1);
        send_stop(rise);
        tick(20);
        exp_id = bits[23:0];
        checks++; if (bus.wavebird_id !== exp_id || id_pulses - i0 != 1) begin
            failures++; $display("FAIL rstmid_next_id got=%h pulses=%0d exp=%h pulses=1", bus.wavebird_id, id_pulses - i0, exp_id);
        end
    endtask

    task automatic test_glitch;
        logic [63:0] bits;
        int i0, e0, rise;
        bits = {$urandom, $urandom};
        bits[0] = 1'b0;
        i0 = id_pulses; e0 = err_pulses;
        arm(1'b1);
        tick(50);
        bus.data_in = 1'b0;
        tick(1);
        bus.data_in = 1'b1;
        tick(300);
        send_bits(bits, 24, 1'b1);
        send_stop(rise);
        tick(BIT_TO + 100);
        if (FILTER_ON) begin
            checks++; if (bus.wavebird_id !== bits[23:0] || id_pulses - i0 != 1 || err_pulses != e0) begin
                failures++; $display("FAIL glitch_filtered got=%h pulses=%0d err=%0d exp=%h pulses=1 err=0", bus.wavebird_id, id_pulses - i0, err_pulses - e0, bits[23:0]);
            end
        end else begin
            checks++; if (!(err_pulses != e0 || bus.wavebird_id !== bits[23:0])) begin
                failures++; $display("FAIL glitch_unfiltered got=%h err=%0d exp corrupted id or error", bus.wavebird_id, err_pulses - e0);
            end
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_id_reply();
        test_poll_reply();
        test_no_response();
        test_truncated();
        test_send_abort();
        test_reset_mid_frame();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gc_response_rx.md
Name: gc_response_rx

Overview:
- Receives and decodes the controller's reply on the shared GameCube data line after each command from the query transmitter.
- Produces the 24-bit ID reply consumed by the init state logic (`wavebird_id`, `wavebird_id_ready`) and the 64-bit button/stick reply from status polls.
- Sits directly downstream of the query sender on the same bidirectional line; samples the line only while the sender is not driving.

Parameters:
- CYCLES_PER_US, 100, clock cycles per microsecond.
- SAMPLE_US, 2, delay from a bit's falling edge to its sample point, in µs.
- BIT_TIMEOUT_US, 6, maximum time in a single bit phase (low or high) before the frame aborts, in µs.
- RESP_TIMEOUT_US, 100, maximum wait from arming to the first falling edge, in µs.

Ports:
- clk100mhz  input  1  system clock, 100 MHz.
- rst  input  1  synchronous reset, active-high.
- data_in  input  1  raw level of the controller data line; asynchronous to clk100mhz.
- send  input  1  high while the query sender drives the line; a 1→0 transition arms reception.
- controller_init  input  1  selects expected reply length: 1 = 24 bits (ID reply), 0 = 64 bits (poll reply).
- wavebird_id  output  24  last ID reply; first received bit at index 0.
- wavebird_id_ready  output  1  one-cycle pulse when wavebird_id updates.
- buttons  output  64  last poll reply; first received bit at index 0.
- buttons_valid  output  1  one-cycle pulse when buttons updates.
- rx_error  output  1  one-cycle pulse on timeout or malformed frame.
- busy  output  1  high from arming until DONE or abort.

Behaviour:
- Input conditioning: data_in passes through a 2-flop synchronizer. A falling edge is synchronized level 1 in the previous cycle and 0 in the current cycle. All timing counts from the cycle the edge is detected.
- Reset: all outputs 0, shift register 0, state IDLE. Reset mid-frame discards partial data and emits no pulses.
- Length latch: the expected length N (24 or 64) is latched from controller_init at arming; later changes to controller_init are ignored for that frame.
- Bit decode: sample at SAMPLE_US·CYCLES_PER_US cycles after the falling edge. Sampled low = 0, high = 1. Bit k is stored at index k.
- Cycle counter: 1 counter, reset on every state change, at least clog2(RESP_TIMEOUT_US·CYCLES_PER_US)+1 bits wide. Bit counter: 7 bits.
- States:
  - IDLE: wait for a send 1→0 transition → ARMED; busy=1.
  - ARMED: falling edge → LOW. RESP_TIMEOUT expiry → rx_error, IDLE. send re-asserted → IDLE, no error.
  - LOW: counter reaches the sample point → shift in the bit, bit_cnt+1 → WAIT_HIGH.
  - WAIT_HIGH: line high → WAIT_FALL. BIT_TIMEOUT expiry while low → rx_error, IDLE.
  - WAIT_FALL: falling edge with bit_cnt<N → LOW. Falling edge with bit_cnt==N → STOP. BIT_TIMEOUT expiry while high → rx_error, IDLE.
  - STOP: the controller stop bit is low about 1 µs, then high. Line high → DONE. BIT_TIMEOUT expiry while low → rx_error, IDLE.
  - DONE: for 1 cycle, copy the shift register to wavebird_id (N=24) or buttons (N=64) and pulse the matching ready/valid flag. Then → IDLE; busy=0 in IDLE.
- Output stability: outputs hold their last good value; an aborted frame never modifies them.
- send asserted in any non-IDLE state: abort to IDLE, no error pulse, and the frame is discarded.
- Latency: ready/valid pulses 1 cycle after the stop bit's rising edge is detected (3 cycles after the raw edge, including the synchronizer).

Optional Feature:
- Macro: GC_RX_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronizer; edges and samples use the filtered level, adding 2 cycles of latency. A single-cycle pulse on data_in never produces an edge.
- Undefined: synchronizer output is used directly, and a 1-cycle low glitch counts as a falling edge.

Test Plan:
- ID reply: controller_init=1; drop send; after 10 µs drive 24 bits with wire order bytes 0x09,0x00,0x00 (MSB-first per byte), then stop bit → wavebird_id[7:0]=8'b10010000, wavebird_id[23:8]=0; one wavebird_id_ready pulse; buttons unchanged.
- Poll reply: controller_init=0; drive 64 bits of alternating 1,0 starting with 1, then stop bit → buttons=64'h5555_5555_5555_5555; one buttons_valid pulse; no rx_error.
- No response: controller_init=0; drop send; line idle high → rx_error pulses exactly 10000 cycles after arming; outputs unchanged; busy falls.
- Truncated frame: 30 poll bits, then line held high → rx_error 600 cycles after the last rising edge; buttons unchanged.
- Reset mid-frame: rst high for 1 cycle after bit 12 → state IDLE, no pulses; the next full ID reply decodes correctly.
- Glitch: 1-cycle low on data_in while ARMED → with GC_RX_GLITCH_FILTER_EN, no decode and the following real frame decodes correctly; without it, the bench expects the frame to be corrupted or an rx_error pulse.
